// File: rtl/btn_step_ctrl.sv
// -----------------------------------------------------------------------------
// btn_step_ctrl
//
// Multi-channel push-button front end for single-step debug of the pipelined
// MIPS core. Each channel has a 2-FF synchroniser, a debounce filter, a clean
// debounced level and a one-clock press pulse. The pulses drive the core's
// step clock, step reset and display-page buttons.
//
// Build option:
//   BTN_STEP_REPEAT_EN  when defined, a held button auto-repeats: an extra
//                       pulse REPEAT_DELAY cycles after the press pulse, then
//                       one every REPEAT_PERIOD cycles until release. When
//                       undefined, the repeat logic is not built and each
//                       press gives exactly one pulse.
//
// Ports:
//   clk      in   1       system clock
//   reset    in   1       asynchronous, active-high reset. Its release is
//                         expected to be synchronous to clk upstream.
//   clear    in   1       synchronous flush: counters to 0, pulses suppressed,
//                         level reloaded from the synchronised input
//   btn_i    in   NUM_CH  raw asynchronous button inputs, bit n = channel n
//   level_o  out  NUM_CH  debounced button level
//   pulse_o  out  NUM_CH  one-clock pulse per accepted press (and per repeat)
//
// Handshake: none. Inputs are levels and outputs are levels or single-cycle
// strobes, with no valid/ready flow control.
// -----------------------------------------------------------------------------
module btn_step_ctrl #(
  parameter int NUM_CH          = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [NUM_CH-1:0] btn_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] pulse_o
);

  // The debounce counter only reaches DEBOUNCE_CYCLES-1 before it is reloaded.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  if (NUM_CH < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_param_check
    $error("btn_step_ctrl: all parameters must be >= 1");
  end

  logic [NUM_CH-1:0] s1;
  logic [NUM_CH-1:0] s2;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] pulse;

  // Two-flop synchroniser. Only s2 is allowed to reach the filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_i;
      s2 <= s1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_nxt;
    logic          press;
    logic          pulse_nxt;

    // Debounce: a level change is accepted only after the synchronised input
    // has disagreed with the current level for DEBOUNCE_CYCLES consecutive
    // edges. Any agreeing sample restarts the count.
    always_comb begin
      cnt_nxt   = cnt;
      level_nxt = level[ch];
      press     = 1'b0;
      if (clear) begin
        // Reload the level silently so a button held across clear never fires.
        cnt_nxt   = '0;
        level_nxt = s2[ch];
      end else if (s2[ch] == level[ch]) begin
        cnt_nxt = '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_nxt   = '0;
        level_nxt = s2[ch];
        press     = s2[ch];
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end

`ifdef BTN_STEP_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_nxt;
    logic          rphase;     // 0: waiting for the first repeat, 1: periodic
    logic          rphase_nxt;
    logic [RW-1:0] rlim;
    logic          rep;

    // rcnt counts edges since the press pulse (or since the last repeat).
    // It fires only while the level stays high across the edge, so a release
    // never coincides with a repeat pulse.
    always_comb begin
      rcnt_nxt   = rcnt;
      rphase_nxt = rphase;
      rep        = 1'b0;
      rlim       = rphase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
      if (clear || !level_nxt || !level[ch]) begin
        rcnt_nxt   = '0;
        rphase_nxt = 1'b0;
      end else if (rcnt == rlim) begin
        rep        = 1'b1;
        rcnt_nxt   = '0;
        rphase_nxt = 1'b1;
      end else begin
        rcnt_nxt = rcnt + RW'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else begin
        rcnt   <= rcnt_nxt;
        rphase <= rphase_nxt;
      end
    end

    assign pulse_nxt = press | rep;
`else
    assign pulse_nxt = press;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt       <= '0;
        level[ch] <= 1'b0;
        pulse[ch] <= 1'b0;
      end else begin
        cnt       <= cnt_nxt;
        level[ch] <= level_nxt;
        pulse[ch] <= pulse_nxt;
      end
    end
  end

  assign level_o = level;
  assign pulse_o = pulse;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_step_ctrl
//
// Bench for btn_step_ctrl with NUM_CH=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. A behavioural model tracks each channel in terms of edge
// counts: the input seen by the filter is the button value from two edges
// earlier, the level flips after DEB consecutive disagreeing samples, and
// repeat pulses are scheduled by age since the press.
// -----------------------------------------------------------------------------
module tb_btn_step_ctrl;

  localparam int NCH = 2;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic           clk;
  logic           reset;
  logic           clear;
  logic [NCH-1:0] btn;
  logic [NCH-1:0] level_o;
  logic [NCH-1:0] pulse_o;

  btn_step_ctrl #(
    .NUM_CH(NCH),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .btn_i(btn),
    .level_o(level_o),
    .pulse_o(pulse_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [2*NCH-1:0] exp_q[$];   // {level, pulse} expected after each edge

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NCH-1:0] m_d1, m_d2;     // button value one and two edges back
  logic [NCH-1:0] m_level;
  int             m_run [NCH];    // consecutive disagreeing samples
  int             m_age [NCH];    // edges since the press while held

  task automatic model_reset();
    m_d1    = '0;
    m_d2    = '0;
    m_level = '0;
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0;
      m_age[i] = 0;
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle, advance the model by one edge, then compare #1 later.
  task automatic step(input logic [NCH-1:0] b, input logic c);
    logic [NCH-1:0]   seen;
    logic [NCH-1:0]   m_pulse;
    logic             old;
    logic [2*NCH-1:0] e;
    btn   = b;
    clear = c;
    @(posedge clk);
    seen    = m_d2;
    m_d2    = m_d1;
    m_d1    = b;
    m_pulse = '0;
    for (int i = 0; i < NCH; i++) begin
      old = m_level[i];
      if (c) begin
        m_level[i] = seen[i];
        m_run[i]   = 0;
        m_age[i]   = 0;
      end else if (seen[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_level[i] = seen[i];
          m_run[i]   = 0;
          if (seen[i]) begin
            m_pulse[i] = 1'b1;
            m_age[i]   = 0;
          end
        end
      end else begin
        m_run[i] = 0;
      end
`ifdef BTN_STEP_REPEAT_EN
      if (!c && old && m_level[i]) begin
        m_age[i]++;
        if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0))
          m_pulse[i] = 1'b1;
      end
`else
      if (old) m_age[i] = 0;
`endif
    end
    exp_q.push_back({m_level, m_pulse});
    #1;
    e = exp_q.pop_front();
    check("level", 32'(level_o), 32'(e[2*NCH-1:NCH]));
    check("pulse", 32'(pulse_o), 32'(e[NCH-1:0]));
  endtask

  task automatic idle(input logic [NCH-1:0] b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int lat;
  int npulse;
  int exp_cnt;
  int age;
  logic [NCH-1:0] rb;

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    btn   = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_level", 32'(level_o), 0);
    check("reset_pulse", 32'(pulse_o), 0);
    @(negedge clk);
    reset = 1'b0;

    // Both buttons held to a high level, then reset asserted mid-clock.
    idle(2'b11, 10);
    check("held_level", 32'(level_o), 32'h3);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_level", 32'(level_o), 0);
    check("async_rst_pulse", 32'(pulse_o), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_level", 32'(level_o), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Held through reset: a new press on both channels, same-cycle pulses.
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step(2'b11, 1'b0);
      if (lat == 0 && pulse_o == 2'b11) lat = k;
    end
    check("rst_held_lat", 32'(lat), 32'(DEB + 2));

    // Release ch1 only: level drops without a pulse.
    npulse = 0;
    for (int k = 0; k < 10; k++) begin
      step(2'b01, 1'b0);
      npulse += int'(pulse_o[1]);
    end
    check("rel_ch1_level", 32'(level_o), 32'h1);
    check("rel_ch1_pulse", 32'(npulse), 0);
    idle(2'b00, 10);

    // Single press on ch0 held for 30 cycles.
    lat    = 0;
    npulse = 0;
    for (int k = 1; k <= 30; k++) begin
      step(2'b01, 1'b0);
      if (lat == 0 && pulse_o[0]) lat = k;
      npulse += int'(pulse_o[0]);
    end
    check("press_lat", 32'(lat), 32'(DEB + 2));
    check("press_level", 32'(level_o), 32'h1);
`ifdef BTN_STEP_REPEAT_EN
    exp_cnt = 0;
    for (int e = 1; e <= 30; e++) begin
      age = e - (DEB + 2);
      if (age == 0 || age == RD || (age > RD && (age - RD) % RP == 0)) exp_cnt++;
    end
`else
    exp_cnt = 1;
`endif
    check("hold_pulses", 32'(npulse), 32'(exp_cnt));
    idle(2'b00, 10);

    // Short press: no acceptance.
    npulse = 0;
    for (int k = 0; k < 3; k++) begin
      step(2'b01, 1'b0);
      npulse += int'(pulse_o[0]);
    end
    for (int k = 0; k < 8; k++) begin
      step(2'b00, 1'b0);
      npulse += int'(pulse_o[0]);
    end
    check("short_level", 32'(level_o), 0);
    check("short_pulse", 32'(npulse), 0);

    // One-cycle low glitch while held: no release, no extra pulse.
    idle(2'b01, 8);
    npulse = 0;
    step(2'b00, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(2'b01, 1'b0);
      npulse += int'(pulse_o[0]);
    end
    check("glitch_level", 32'(level_o), 32'h1);
    check("glitch_pulse", 32'(npulse), 0);
    idle(2'b00, 10);

    // Hold ch0 across a clear pulse raised mid-debounce.
    idle(2'b01, 3);
    npulse = 0;
    step(2'b01, 1'b1);
    npulse += int'(pulse_o[0]);
    for (int k = 0; k < 8; k++) begin
      step(2'b01, 1'b0);
      npulse += int'(pulse_o[0]);
    end
    check("clear_pulse", 32'(npulse), 0);
    check("clear_level", 32'(level_o), 32'h1);
    idle(2'b00, 10);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      step(2'b01, 1'b0);
      if (lat == 0 && pulse_o[0]) lat = k;
    end
    check("after_clear_lat", 32'(lat), 32'(DEB + 2));
    idle(2'b00, 10);

    // Randomised sticky buttons with occasional clear.
    rb = '0;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 5) == 0) rb = rb ^ NCH'($urandom_range(1, (1 << NCH) - 1));
      step(rb, $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
